y_demux_stream: RTL and testbench
=================================

// Module: y_demux_stream
// PURPOSE
//  1-to-NOUT stream demultiplexer, the inverse of the yMux selector family.
//  One input word plus a select index is steered to exactly one of NOUT outputs.
//  Each output is backed by a one-entry registered slot with valid/ready handshake.
//  Sits between the datapath result bus and per-unit consumers (regfile write, mem, PC).
// PARAMETERS
//  WIDTH  32  data word width in bits
//  NOUT   4   number of output channels, 2..16
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_valid   in   1           input word present
//  in_ready   out  1           block accepts input this cycle
//  in_data    in   WIDTH       input word
//  in_sel     in   SEL_W       destination index; SEL_W = max(1,$clog2(NOUT))
//  out_valid  out  NOUT        per-channel word present
//  out_ready  in   NOUT        per-channel consumer accepts
//  out_data   out  NOUT*WIDTH  channel k on bits [k*WIDTH +: WIDTH]
//  drop_cnt   out  8           count of words dropped for in_sel >= NOUT, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): all slots EMPTY, out_valid=0, out_data=0, drop_cnt=0.
//    Reset mid-transfer discards held words; no partial outputs remain.
//  - Per-slot FSM: EMPTY -> FULL on accept; FULL -> EMPTY on out_ready without refill;
//    FULL -> FULL on out_ready with a same-cycle refill, new word replaces old.
//  - Input accept = in_valid & in_ready.
//    in_ready = (in_sel >= NOUT) | ~full[in_sel] | out_ready[in_sel].
//  - Accepted word appears on out_data[in_sel] with out_valid set the next cycle.
//    Latency is 1 cycle; throughput is 1 word/cycle per channel.
//  - Output handshake: out_valid[k] & out_ready[k] completes the transfer.
//    While out_valid[k]=1 and out_ready[k]=0, out_data[k] holds stable.
//  - in_ready depends combinationally on out_ready of the selected channel only.
//    out_valid never depends combinationally on any input.
//  - Invalid select (in_sel >= NOUT, possible when NOUT is not a power of 2):
//    in_ready=1, the word is consumed and discarded, and drop_cnt increments.
//    drop_cnt saturates at 255 and never wraps.
//  - Non-selected channels are unaffected by input traffic.
//    A full slot blocks only its own channel, with no head-of-line blocking across channels.
//  - in_valid=0: no slot state changes except drains.
//    Unknown in_sel with in_valid=0 is ignored.
// CONFIGURATION
//  Y_DEMUX_STATS_EN defined:
//    - Adds output port xfer_cnt (NOUT*16): per-channel 16-bit count of completed
//      output handshakes.
//    - Counters wrap modulo 2^16 and reset to 0 on rst_n.
//  Y_DEMUX_STATS_EN undefined:
//    - Port xfer_cnt absent, no counter logic; all other behaviour identical.
// STRUCTURE
//  Package y_demux_pkg:
//    - typedef enum {SLOT_EMPTY, SLOT_FULL} slot_state_t
//    - localparam DROP_W = 8, XFER_W = 16
//  Sub-module y_demux_slot (WIDTH):
//    - one-entry register with load/drain ports, outputs full/valid/data
//    - instantiated NOUT times via generate
//  Top level holds the select decode, the in_ready mux, drop_cnt and optional stats.
// TESTING
//  1. NOUT=4, idle outputs ready; send 0xA5 sel=2.
//     Expect out_valid=4'b0100 and out_data[2]=0xA5 one cycle later.
//  2. Hold out_ready[1]=0; send words to ch1 twice.
//     First accepted; second sees in_ready=0 until out_ready[1]=1; no data loss or reorder.
//  3. Ch1 full with out_ready[1]=1, send new word to ch1 the same cycle.
//     Accepted; next cycle out_data[1] equals the new word and out_valid[1] stays 1.
//  4. NOUT=3, send sel=3 three times.
//     in_ready=1, no out_valid asserted, drop_cnt=3; after 300 sends drop_cnt=255.
//  5. Ch0 stalled full, stream to ch2/ch3 back-to-back.
//     1 word/cycle accepted, ch0 data unchanged.
//  6. Assert rst_n=0 mid-stream, asynchronously between edges.
//     out_valid=0 and drop_cnt=0 immediately; with STATS_EN, xfer_cnt=0.

Source files
------------

// File: rtl/y_demux_pkg.sv
// y_demux_pkg: shared types and constants for the y_demux_stream block.
//   slot_state_t : per-channel slot FSM encoding
//   DROP_W       : width of the saturating drop counter
//   XFER_W       : width of each per-channel transfer counter (Y_DEMUX_STATS_EN)
//   sel_width()  : select width for a channel count, never below 1
package y_demux_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int DROP_W = 8;
    localparam int XFER_W = 16;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/y_demux_slot.sv
// y_demux_slot: one-entry registered output slot with valid/ready semantics.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : write i_data into the slot this cycle
//   i_drain        : consumer ready; empties a full slot unless refilled
//   i_data         : word to load
//   o_full/o_valid : slot holds a word
//   o_data         : held word (cleared only by reset)
//
// state      | meaning
// SLOT_EMPTY | no word held, o_valid low
// SLOT_FULL  | word held and presented, o_data stable until drained
module y_demux_slot
    import y_demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_drain,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    // A load into a full slot is only granted alongside a drain, so the
    // refill case simply stays FULL with the new word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (i_drain && !i_load) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        o_full  = (r_state == SLOT_FULL);
        o_valid = (r_state == SLOT_FULL);
        o_data  = r_data;
    end

endmodule

// File: rtl/y_demux_stream.sv
// y_demux_stream: 1-to-NOUT stream demultiplexer with one registered slot per channel.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_in_valid     : input word present
//   o_in_ready     : input accepted this cycle when high together with i_in_valid
//   i_in_data      : input word
//   i_in_sel       : destination channel; values >= NOUT are dropped
//   o_out_valid    : per-channel word present (registered)
//   i_out_ready    : per-channel consumer ready
//   o_out_data     : channel k on bits [k*WIDTH +: WIDTH]
//   o_drop_cnt     : saturating count of words dropped for an invalid select
//   o_xfer_cnt     : per-channel 16-bit wrapping count of completed output
//                    handshakes, present only when Y_DEMUX_STATS_EN is defined
module y_demux_stream
    import y_demux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NOUT  = 4,
    localparam int SEL_W = sel_width(NOUT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [WIDTH-1:0]      i_in_data,
    input  logic [SEL_W-1:0]      i_in_sel,
    output logic [NOUT-1:0]       o_out_valid,
    input  logic [NOUT-1:0]       i_out_ready,
    output logic [NOUT*WIDTH-1:0] o_out_data,
`ifdef Y_DEMUX_STATS_EN
    output logic [NOUT*XFER_W-1:0] o_xfer_cnt,
`endif
    output logic [DROP_W-1:0]     o_drop_cnt
);

    logic [NOUT-1:0]   w_full;
    logic [NOUT-1:0]   w_valid;
    logic [NOUT-1:0]   w_load;
    logic              w_sel_ok;
    logic              w_sel_full;
    logic              w_sel_ordy;
    logic              w_in_ready;
    logic              w_drop;
    logic [DROP_W-1:0] r_drop;

    // One extra bit so NOUT itself is representable when NOUT is a power of 2.
    assign w_sel_ok = ({1'b0, i_in_sel} < (SEL_W+1)'(NOUT));

    // in_ready looks only at the selected channel, so a stalled channel never
    // blocks traffic to the others.
    always_comb begin
        w_sel_full = 1'b0;
        w_sel_ordy = 1'b0;
        w_load     = '0;
        for (int k = 0; k < NOUT; k++) begin
            if (i_in_sel == SEL_W'(k)) begin
                w_sel_full = w_full[k];
                w_sel_ordy = i_out_ready[k];
            end
        end
        w_in_ready = ~w_sel_ok | ~w_sel_full | w_sel_ordy;
        for (int k = 0; k < NOUT; k++) begin
            w_load[k] = i_in_valid & w_sel_ok & (i_in_sel == SEL_W'(k)) & w_in_ready;
        end
    end

    assign o_in_ready = w_in_ready;

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        y_demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_load  (w_load[k]),
            .i_drain (i_out_ready[k]),
            .i_data  (i_in_data),
            .o_full  (w_full[k]),
            .o_valid (w_valid[k]),
            .o_data  (o_out_data[k*WIDTH +: WIDTH])
        );
    end

    assign o_out_valid = w_valid;

    assign w_drop = i_in_valid & ~w_sel_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
            r_drop <= r_drop + DROP_W'(1);
        end
    end

    assign o_drop_cnt = r_drop;

`ifdef Y_DEMUX_STATS_EN
    logic [XFER_W-1:0] r_xfer [NOUT];

    for (genvar k = 0; k < NOUT; k++) begin : g_xfer
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_xfer[k] <= '0;
            end else if (w_valid[k] && i_out_ready[k]) begin
                r_xfer[k] <= r_xfer[k] + XFER_W'(1);
            end
        end
        assign o_xfer_cnt[k*XFER_W +: XFER_W] = r_xfer[k];
    end
`else
    // Transfer statistics not built.
`endif

endmodule

// File: tb/tb_y_demux_stream.sv
module tb_y_demux_stream;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         v4, rdy4;
    logic [31:0]  data4;
    logic [1:0]   sel4;
    logic [3:0]   ov4, ordy4;
    logic [127:0] od4;
    logic [7:0]   drop4;

    logic         v3, rdy3;
    logic [31:0]  data3;
    logic [1:0]   sel3;
    logic [2:0]   ov3, ordy3;
    logic [95:0]  od3;
    logic [7:0]   drop3;

`ifdef Y_DEMUX_STATS_EN
    logic [63:0]  xfer4;
    logic [47:0]  xfer3;
    int           exp_xfer [4];
`endif

    logic [31:0]  sb [4][$];
    int           exp_drop3;
    logic [2:0]   exp_v3;
    logic [31:0]  exp_d3;
    int           total;
    int           bad;

    always #5 clk = ~clk;

    y_demux_stream #(.WIDTH(32), .NOUT(4)) u_dut4 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (v4),
        .o_in_ready  (rdy4),
        .i_in_data   (data4),
        .i_in_sel    (sel4),
        .o_out_valid (ov4),
        .i_out_ready (ordy4),
        .o_out_data  (od4),
`ifdef Y_DEMUX_STATS_EN
        .o_xfer_cnt  (xfer4),
`endif
        .o_drop_cnt  (drop4)
    );

    y_demux_stream #(.WIDTH(32), .NOUT(3)) u_dut3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (v3),
        .o_in_ready  (rdy3),
        .i_in_data   (data3),
        .i_in_sel    (sel3),
        .o_out_valid (ov3),
        .i_out_ready (ordy3),
        .o_out_data  (od3),
`ifdef Y_DEMUX_STATS_EN
        .o_xfer_cnt  (xfer3),
`endif
        .o_drop_cnt  (drop3)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: compare against the scoreboard before the edge,
    // update the model with the handshakes the edge will complete.
    task automatic cycle();
        logic exp_rdy;
        exp_rdy = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("valid4", ov4[k], sb[k].size() != 0);
            if (sb[k].size() != 0) chk("data4", od4[k*32 +: 32], sb[k][0]);
`ifdef Y_DEMUX_STATS_EN
            chk("xfer4", xfer4[k*16 +: 16], exp_xfer[k][15:0]);
`endif
        end
        if (v4) begin
            exp_rdy = (sb[sel4].size() == 0) || ordy4[sel4];
            chk("ready4", rdy4, exp_rdy);
        end
        for (int k = 0; k < 4; k++) begin
            if (sb[k].size() != 0 && ordy4[k]) begin
                void'(sb[k].pop_front());
`ifdef Y_DEMUX_STATS_EN
                exp_xfer[k]++;
`endif
            end
        end
        if (v4 && exp_rdy) sb[sel4].push_back(data4);

        chk("valid3", ov3, exp_v3);
        chk("drop3", drop3, exp_drop3[7:0]);
        if (exp_v3 != 3'b000) begin
            for (int k = 0; k < 3; k++) begin
                if (exp_v3[k]) chk("data3", od3[k*32 +: 32], exp_d3);
            end
        end
        if (v3) chk("ready3", rdy3, 1'b1);
        if (v3 && sel3 == 2'd3 && exp_drop3 != 255) exp_drop3++;
        exp_v3 = (v3 && sel3 < 2'd3) ? (3'b001 << sel3) : 3'b000;
        exp_d3 = data3;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_drop3 = 0;
        exp_v3 = 3'b000;
        exp_d3 = '0;
`ifdef Y_DEMUX_STATS_EN
        for (int k = 0; k < 4; k++) exp_xfer[k] = 0;
`endif
        v4 = 0; sel4 = 0; data4 = 0; ordy4 = 4'b1111;
        v3 = 0; sel3 = 0; data3 = 0; ordy3 = 3'b111;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid4", ov4, 4'b0000);
        chk("rst_data4", od4, 128'h0);
        chk("rst_drop3", drop3, 8'd0);
        chk("rst_valid3", ov3, 3'b000);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single word to channel 2
        v4 = 1; sel4 = 2'd2; data4 = 32'hA5;
        cycle();
        v4 = 0;
        chk("t1_valid", ov4, 4'b0100);
        chk("t1_data", od4[64 +: 32], 32'hA5);
        cycle();
        cycle();

        // channel 1 stalled, second word waits, then same-cycle refill
        ordy4 = 4'b1101;
        v4 = 1; sel4 = 2'd1; data4 = 32'h1111_0001;
        cycle();
        data4 = 32'h1111_0002;
        cycle();
        chk("t2_blocked", rdy4, 1'b0);
        cycle();
        ordy4 = 4'b1111;
        cycle();
        chk("t3_refill_valid", ov4[1], 1'b1);
        chk("t3_refill_data", od4[32 +: 32], 32'h1111_0002);
        v4 = 0;
        cycle();
        cycle();

        // channel 0 stalled full, ch2/ch3 stream back-to-back
        ordy4 = 4'b1110;
        v4 = 1; sel4 = 2'd0; data4 = 32'hC0C0_C0C0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            sel4 = (i % 2 == 0) ? 2'd2 : 2'd3;
            data4 = $urandom;
            #1;
            chk("t5_ready", rdy4, 1'b1);
            cycle();
            chk("t5_ch0_hold", od4[31:0], 32'hC0C0_C0C0);
        end
        v4 = 0;
        cycle();
        ordy4 = 4'b1111;
        cycle();
        cycle();

        // invalid select on the NOUT=3 instance
        v3 = 1; sel3 = 2'd3; data3 = 32'hDEAD_0003;
        cycle();
        cycle();
        cycle();
        v3 = 0;
        cycle();
        chk("t4_drop3", drop3, 8'd3);
        v3 = 1; sel3 = 2'd1; data3 = 32'h0000_3131;
        cycle();
        v3 = 0;
        cycle();
        v3 = 1; sel3 = 2'd3;
        for (int i = 0; i < 297; i++) cycle();
        v3 = 0;
        cycle();
        chk("t4_drop_sat", drop3, 8'd255);

        // asynchronous reset in the middle of traffic
        ordy4 = 4'b0000;
        v4 = 1; v3 = 1; sel3 = 2'd3;
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            data4 = 32'h6000_0000 + 32'(i);
            cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid4", ov4, 4'b0000);
        chk("t6_data4", od4, 128'h0);
        chk("t6_valid3", ov3, 3'b000);
        chk("t6_drop3", drop3, 8'd0);
`ifdef Y_DEMUX_STATS_EN
        chk("t6_xfer4", xfer4, 64'h0);
        chk("t6_xfer3", xfer3, 48'h0);
        for (int k = 0; k < 4; k++) exp_xfer[k] = 0;
`endif
        for (int k = 0; k < 4; k++) sb[k].delete();
        exp_drop3 = 0;
        exp_v3 = 3'b000;
        v4 = 0; v3 = 0; ordy4 = 4'b1111;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        v4 = 1; sel4 = 2'd3; data4 = 32'h7777_0003;
        cycle();
        v4 = 0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
